// File: rtl/hazard3_cir_queue_if.sv
// Handshake bundle between fetch, the CIR halfword queue and decode.
// master: fetch/decode side that drives data, jumps and retirement.
// slave:  the queue itself.
interface hazard3_cir_queue_if;
  logic [31:0] f_rdata;
  logic        f_rdata_vld;
  logic        f_rdata_rdy;
  logic        f_jump_now;
  logic [31:0] f_jump_target;
  logic [31:0] fd_cir;
  logic [1:0]  fd_cir_vld;
  logic [1:0]  df_cir_use;
  logic        df_cir_lock;

  modport master (
    output f_rdata, f_rdata_vld, f_jump_now, f_jump_target, df_cir_use, df_cir_lock,
    input  f_rdata_rdy, fd_cir, fd_cir_vld
  );

  modport slave (
    input  f_rdata, f_rdata_vld, f_jump_now, f_jump_target, df_cir_use, df_cir_lock,
    output f_rdata_rdy, fd_cir, fd_cir_vld
  );
endinterface

// File: rtl/hazard3_cir_queue.sv
// Fetch-side halfword queue producing the current instruction register.
// Fetch words enter as two halfwords (or only the upper one after a jump to
// a halfword-aligned target); decode retires 0..2 halfwords per cycle.
// Optional feature macro: HAZARD3_CIR_BYPASS_EN -- when defined, a word
// arriving at an empty queue is presented on fd_cir in the same cycle.
module hazard3_cir_queue #(
  parameter int          DEPTH        = 6,
  parameter logic [31:0] RESET_VECTOR = 32'h0,
  localparam int         LW           = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  hazard3_cir_queue_if.slave   bus,
  output logic [LW-1:0]        level
);

  localparam logic [LW-1:0] RDY_MAX = LW'(DEPTH - 2);

  logic [15:0]   q      [DEPTH];
  logic [15:0]   ext    [DEPTH+2];
  logic [15:0]   q_nxt  [DEPTH];
  logic          drop_lo;
  logic [1:0]    reg_vld;
  logic          push;
  logic [1:0]    push_cnt;
  logic [15:0]   ph0;
  logic [15:0]   ph1;
  logic [LW-1:0] level_nxt;
  logic [1:0]    keep;
  logic          unused_jump_bits;

  // Only bit 1 of the target matters: it says whether the first fetched
  // halfword lies below the target and must be dropped.
  assign unused_jump_bits = ^{bus.f_jump_target[31:2], bus.f_jump_target[0]};

  assign reg_vld         = (level >= LW'(2)) ? 2'd2 : level[1:0];
  assign bus.f_rdata_rdy = (level <= RDY_MAX);
  assign push            = bus.f_rdata_vld && bus.f_rdata_rdy && !bus.f_jump_now;
  assign push_cnt        = drop_lo ? 2'd1 : 2'd2;
  assign ph0             = drop_lo ? bus.f_rdata[31:16] : bus.f_rdata[15:0];
  assign ph1             = bus.f_rdata[31:16];

`ifdef HAZARD3_CIR_BYPASS_EN
  // CIR view: stored halfwords, or the incoming word when the queue is empty.
  always_comb begin
    bus.fd_cir     = {q[1], q[0]};
    bus.fd_cir_vld = reg_vld;
    if (level == '0 && push) begin
      bus.fd_cir     = {ph1, ph0};
      bus.fd_cir_vld = push_cnt;
    end
  end
`else
  assign bus.fd_cir     = {q[1], q[0]};
  assign bus.fd_cir_vld = reg_vld;
`endif

  // Extended view: stored entries with the pushed halfwords placed at level.
  // NOTE: every output of a combinational block gets a default before any
  // conditional write, otherwise synthesis infers latches.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) ext[i] = q[i];
    ext[DEPTH]   = '0;
    ext[DEPTH+1] = '0;
    if (push) begin
      for (int i = 0; i < DEPTH + 2; i++) begin
        if (i == int'(level))                    ext[i] = ph0;
        else if (i == int'(level) + 1 && !drop_lo) ext[i] = ph1;
      end
    end
  end

  // Retire by shifting the extended view down by df_cir_use.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      case (bus.df_cir_use)
        2'd1:    q_nxt[i] = ext[i+1];
        2'd2:    q_nxt[i] = ext[i+2];
        default: q_nxt[i] = ext[i];
      endcase
    end
    level_nxt = level + LW'(push_cnt & {2{push}}) - LW'(bus.df_cir_use);
  end

  // Halfwords of the locked instruction kept across a jump.
  always_comb begin
    keep = (q[0][1:0] == 2'b11) ? 2'd2 : 2'd1;
    if (keep > reg_vld) keep = reg_vld;
  end

  // Queue state: reset, jump flush (optionally keeping the locked CIR), or
  // normal retire-and-append.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  // NOTE: the storage array is reset because fd_cir must read zero after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      level   <= '0;
      drop_lo <= RESET_VECTOR[1];
      for (int i = 0; i < DEPTH; i++) q[i] <= '0;
    end else if (bus.f_jump_now) begin
      level   <= bus.df_cir_lock ? LW'(keep) : '0;
      drop_lo <= bus.f_jump_target[1];
    end else begin
      level <= level_nxt;
      for (int i = 0; i < DEPTH; i++) q[i] <= q_nxt[i];
      if (push) drop_lo <= 1'b0;
    end
  end

  a_use_legal: assert property (@(posedge clk) disable iff (rst)
    bus.df_cir_use <= bus.fd_cir_vld);
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    level <= LW'(DEPTH));

endmodule

// File: tb/tb_hazard3_cir_queue.sv
// Self-checking bench for hazard3_cir_queue: directed scenarios followed by
// randomized traffic, all compared against a halfword-queue reference model.
module tb_hazard3_cir_queue;
  localparam int DEPTH = 6;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] level;
  logic [2:0] level2;

  always #5 clk = ~clk;

  hazard3_cir_queue_if bus ();
  hazard3_cir_queue_if bus2 ();

  hazard3_cir_queue #(.DEPTH(DEPTH), .RESET_VECTOR(32'h0)) dut (
    .clk(clk), .rst(rst), .bus(bus), .level(level)
  );

  hazard3_cir_queue #(.DEPTH(DEPTH), .RESET_VECTOR(32'h2)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2), .level(level2)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: FIFO of halfwords plus the pending drop of a low half.
  logic [15:0] mq[$];
  logic        mdrop;
  logic        m_push_ok;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Apply one cycle of inputs at the falling edge and compare outputs.
  // u == 3 picks a random legal retirement count.
  task automatic drive(input logic r, input logic v, input logic [31:0] d, input logic [1:0] u,
                       input logic j, input logic [31:0] t, input logic l);
    logic [15:0] view[$];
    int ev;
    @(negedge clk);
    rst               = r;
    bus.f_rdata_vld   = v;
    bus.f_rdata       = d;
    bus.f_jump_now    = j;
    bus.f_jump_target = t;
    bus.df_cir_lock   = l;
    m_push_ok = v && (mq.size() <= DEPTH - 2) && !j;
    view = mq;
`ifdef HAZARD3_CIR_BYPASS_EN
    if (mq.size() == 0 && m_push_ok) begin
      if (mdrop) view.push_back(d[31:16]);
      else begin
        view.push_back(d[15:0]);
        view.push_back(d[31:16]);
      end
    end
`endif
    ev = (view.size() > 2) ? 2 : view.size();
    if (u == 2'd3) u = (j && l) ? 2'd0 : 2'($urandom_range(0, ev));
    bus.df_cir_use = u;
    #1;
    check("rdy", 32'(bus.f_rdata_rdy), 32'(mq.size() <= DEPTH - 2));
    check("level", 32'(level), mq.size());
    check("vld", 32'(bus.fd_cir_vld), ev);
    for (int k = 0; k < ev; k++) check("cir_hw", 32'(bus.fd_cir[16*k +: 16]), 32'(view[k]));
  endtask

  // Clock edge: advance the reference model using the applied inputs.
  task automatic tick();
    int keep;
    @(posedge clk);
    if (rst) begin
      mq.delete();
      mdrop = 1'b0;
    end else if (bus.f_jump_now) begin
      if (bus.df_cir_lock) begin
        keep = (mq.size() == 0) ? 0 : ((mq[0][1:0] == 2'b11) ? 2 : 1);
        if (keep > mq.size()) keep = mq.size();
        while (mq.size() > keep) void'(mq.pop_back());
      end else begin
        mq.delete();
      end
      mdrop = bus.f_jump_target[1];
    end else begin
      if (m_push_ok) begin
        if (!mdrop) mq.push_back(bus.f_rdata[15:0]);
        mq.push_back(bus.f_rdata[31:16]);
        mdrop = 1'b0;
      end
      for (int k = 0; k < int'(bus.df_cir_use); k++) void'(mq.pop_front());
    end
    #1;
  endtask

  task automatic cyc(input logic v, input logic [31:0] d, input logic [1:0] u);
    drive(1'b0, v, d, u, 1'b0, 32'h0, 1'b0);
    tick();
  endtask

  initial begin
    rst = 1'b1;
    bus.f_rdata = '0;  bus.f_rdata_vld = 1'b0; bus.f_jump_now = 1'b0;
    bus.f_jump_target = '0; bus.df_cir_use = '0; bus.df_cir_lock = 1'b0;
    bus2.f_rdata = '0; bus2.f_rdata_vld = 1'b0; bus2.f_jump_now = 1'b0;
    bus2.f_jump_target = '0; bus2.df_cir_use = '0; bus2.df_cir_lock = 1'b0;
    mdrop = 1'b0;
    repeat (2) @(posedge clk);

    // Reset state
    drive(1'b0, 1'b0, 32'h0, 2'd0, 1'b0, 32'h0, 1'b0);
    check("rst_cir", bus.fd_cir, 32'h0);
    check("rst_vld", 32'(bus.fd_cir_vld), 32'd0);
    check("rst_rdy", 32'(bus.f_rdata_rdy), 32'd1);
    check("rst_level", 32'(level), 32'd0);
    tick();

    // Second instance (reset PC bit 1 set) gets 32'h4505_1234
    bus2.f_rdata     = 32'h4505_1234;
    bus2.f_rdata_vld = 1'b1;

    // Aligned 32-bit instruction through the queue
    drive(1'b0, 1'b1, 32'h00A0_0093, 2'd0, 1'b0, 32'h0, 1'b0);
    tick();
    bus2.f_rdata_vld = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 2'd2, 1'b0, 32'h0, 1'b0);
    check("p1_cir", bus.fd_cir, 32'h00A0_0093);
    check("p1_vld", 32'(bus.fd_cir_vld), 32'd2);
    check("p1_level", 32'(level), 32'd2);
    check("rv2_cir_lo", 32'(bus2.fd_cir[15:0]), 32'h4505);
    check("rv2_vld", 32'(bus2.fd_cir_vld), 32'd1);
    check("rv2_level", 32'(level2), 32'd1);
    tick();
    drive(1'b0, 1'b0, 32'h0, 2'd0, 1'b0, 32'h0, 1'b0);
    check("p1_drain", 32'(level), 32'd0);
    tick();

    // Fill to capacity, then verify back-pressure
    cyc(1'b1, 32'h1111_0000, 2'd0);
    cyc(1'b1, 32'h3333_2222, 2'd0);
    cyc(1'b1, 32'h5555_4444, 2'd0);
    drive(1'b0, 1'b1, 32'hDEAD_BEEF, 2'd0, 1'b0, 32'h0, 1'b0);
    check("full_rdy", 32'(bus.f_rdata_rdy), 32'd0);
    check("full_level", 32'(level), 32'd6);
    tick();
    drive(1'b0, 1'b0, 32'h0, 2'd2, 1'b0, 32'h0, 1'b0);
    check("full_hold", 32'(level), 32'd6);
    tick();
    drive(1'b0, 1'b0, 32'h0, 2'd0, 1'b0, 32'h0, 1'b0);
    check("drain_level", 32'(level), 32'd4);
    check("drain_rdy", 32'(bus.f_rdata_rdy), 32'd1);
    tick();
    cyc(1'b0, 32'h0, 2'd2);
    cyc(1'b0, 32'h0, 2'd2);

    // Mixed compressed / 32-bit stream across a word boundary
    cyc(1'b1, 32'h0001_4581, 2'd0);
    cyc(1'b1, 32'h0000_0513, 2'd0);
    drive(1'b0, 1'b0, 32'h0, 2'd1, 1'b0, 32'h0, 1'b0);
    check("mix_cir0", bus.fd_cir, 32'h0001_4581);
    tick();
    drive(1'b0, 1'b0, 32'h0, 2'd2, 1'b0, 32'h0, 1'b0);
    check("mix_cir1", bus.fd_cir, 32'h0513_0001);
    tick();
    drive(1'b0, 1'b0, 32'h0, 2'd1, 1'b0, 32'h0, 1'b0);
    check("mix_level", 32'(level), 32'd1);
    tick();

    // Locked jump keeping a 32-bit instruction at q[0]
    cyc(1'b1, 32'h0013_2222, 2'd0);
    cyc(1'b1, 32'h7777_5555, 2'd0);
    cyc(1'b1, 32'h9999_8888, 2'd0);
    cyc(1'b0, 32'h0, 2'd1);
    drive(1'b0, 1'b0, 32'h0, 2'd0, 1'b1, 32'h0000_0102, 1'b1);
    check("lock_pre_level", 32'(level), 32'd5);
    check("lock_pre_cir", bus.fd_cir, 32'h5555_0013);
    tick();
    drive(1'b0, 1'b1, 32'hBBBB_AAAA, 2'd0, 1'b0, 32'h0, 1'b0);
    check("lock_level", 32'(level), 32'd2);
    check("lock_cir", bus.fd_cir, 32'h5555_0013);
    tick();
    drive(1'b0, 1'b0, 32'h0, 2'd2, 1'b0, 32'h0, 1'b0);
    check("lock_push_level", 32'(level), 32'd3);
    tick();
    drive(1'b0, 1'b0, 32'h0, 2'd1, 1'b0, 32'h0, 1'b0);
    check("lock_tgt_hw", 32'(bus.fd_cir[15:0]), 32'h0000_BBBB);
    check("lock_tgt_vld", 32'(bus.fd_cir_vld), 32'd1);
    tick();

    // Unlocked jump discards a same-cycle word
    cyc(1'b1, 32'h1234_5678, 2'd0);
    drive(1'b0, 1'b1, 32'hCAFE_F00D, 2'd0, 1'b1, 32'h0, 1'b0);
    tick();
    drive(1'b0, 1'b0, 32'h0, 2'd0, 1'b0, 32'h0, 1'b0);
    check("jmp_level", 32'(level), 32'd0);
    check("jmp_vld", 32'(bus.fd_cir_vld), 32'd0);
    tick();
    drive(1'b0, 1'b1, 32'h0000_0073, 2'd0, 1'b0, 32'h0, 1'b0);
`ifdef HAZARD3_CIR_BYPASS_EN
    check("jmp_bypass_vld", 32'(bus.fd_cir_vld), 32'd2);
`else
    check("jmp_nobypass_vld", 32'(bus.fd_cir_vld), 32'd0);
`endif
    tick();
    drive(1'b0, 1'b0, 32'h0, 2'd2, 1'b0, 32'h0, 1'b0);
    check("jmp_next_vld", 32'(bus.fd_cir_vld), 32'd2);
    check("jmp_next_cir", bus.fd_cir, 32'h0000_0073);
    tick();

    // Randomized traffic against the model
    for (int n = 0; n < 4000; n++) begin
      drive($urandom_range(0, 299) == 0, ($urandom % 4) != 0, $urandom, 2'd3,
            $urandom_range(0, 15) == 0, $urandom, 1'($urandom % 2));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
